// File: rtl/seq_detector_param_if.sv
// Serial-input, control and result signals of the programmable pattern detector.
// master drives the bit stream and controls; slave is the detector.
interface seq_detector_param_if #(
    parameter int PATTERN_LEN = 4,
    parameter int CNT_WIDTH   = 8
);
    logic                   sequence_in;
    logic                   in_valid;
    logic                   overlap_en;
    logic                   pattern_load;
    logic [PATTERN_LEN-1:0] pattern_in;
    logic                   count_clear;
    logic                   detector_out;
    logic [CNT_WIDTH-1:0]   match_count;
    logic [PATTERN_LEN-1:0] pattern_q;

    // Qualified stream: sequence_in is meaningful only in cycles with in_valid=1;
    // there is no backpressure, the detector accepts every qualified bit.
    modport master (
        output sequence_in, in_valid, overlap_en, pattern_load, pattern_in, count_clear,
        input  detector_out, match_count, pattern_q
    );
    modport slave (
        input  sequence_in, in_valid, overlap_en, pattern_load, pattern_in, count_clear,
        output detector_out, match_count, pattern_q
    );
endinterface

// File: rtl/seq_detector_param.sv
// Programmable PATTERN_LEN-bit serial pattern detector with overlap control
// and a saturating match counter.
module seq_detector_param #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN_RST = 4'b1011,
    parameter int                     CNT_WIDTH   = 8
) (
    input logic                  clock,
    input logic                  reset,
    seq_detector_param_if.slave  bus
);
    localparam int FILL_W = (PATTERN_LEN > 2) ? $clog2(PATTERN_LEN) : 1;
    localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(PATTERN_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic [PATTERN_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [PATTERN_LEN-1:0] pattern_q, pattern_d;
    logic                   det_q, det_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;

    logic                   accept;
    logic [PATTERN_LEN-1:0] candidate;
    logic                   hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= PATTERN_RST;
            det_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            det_q     <= det_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        accept    = bus.in_valid && !bus.pattern_load;
        candidate = {hist_q[PATTERN_LEN-2:0], bus.sequence_in};
        // fill at its maximum means the other PATTERN_LEN-1 history bits all arrived since the last restart
        hit       = accept && (fill_q == FILL_MAX) && (candidate == pattern_q);

        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        det_d     = hit;
        count_d   = count_q;

        if (bus.pattern_load) begin
            pattern_d = bus.pattern_in;
            fill_d    = '0;
        end else if (accept) begin
            hist_d = candidate;
            if (hit) begin
                if (!bus.overlap_en) fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end

        // clear outranks a same-cycle hit
        if (bus.count_clear) begin
            count_d = '0;
        end else if (hit && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    assign bus.detector_out = det_q;
    assign bus.match_count  = count_q;
    assign bus.pattern_q    = pattern_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random traffic on two
// configurations, checked against a bits-since-restart reference model.
module tb_seq_detector_param;
    logic clock;
    logic reset;

    // instance 0: 4-bit pattern, 8-bit counter; instance 1: 2-bit pattern, 2-bit counter
    seq_detector_param_if #(.PATTERN_LEN(4), .CNT_WIDTH(8)) if0 ();
    seq_detector_param_if #(.PATTERN_LEN(2), .CNT_WIDTH(2)) if1 ();

    seq_detector_param #(.PATTERN_LEN(4), .PATTERN_RST(4'b1011), .CNT_WIDTH(8)) dut0 (
        .clock(clock), .reset(reset), .bus(if0)
    );
    seq_detector_param #(.PATTERN_LEN(2), .PATTERN_RST(2'b11), .CNT_WIDTH(2)) dut1 (
        .clock(clock), .reset(reset), .bus(if1)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- drive variables ----------------
    logic        d_valid [2];
    logic        d_bit   [2];
    logic        d_ov    [2];
    logic        d_load  [2];
    logic [15:0] d_pin   [2];
    logic        d_clr   [2];

    assign if0.in_valid     = d_valid[0];
    assign if0.sequence_in  = d_bit[0];
    assign if0.overlap_en   = d_ov[0];
    assign if0.pattern_load = d_load[0];
    assign if0.pattern_in   = d_pin[0][3:0];
    assign if0.count_clear  = d_clr[0];
    assign if1.in_valid     = d_valid[1];
    assign if1.sequence_in  = d_bit[1];
    assign if1.overlap_en   = d_ov[1];
    assign if1.pattern_load = d_load[1];
    assign if1.pattern_in   = d_pin[1][1:0];
    assign if1.count_clear  = d_clr[1];

    // ---------------- reference model ----------------
    // m_n counts accepted bits since the last restart (unbounded); a hit is
    // "at least L bits since restart and the last L bits equal the pattern".
    int          len_v  [2] = '{4, 2};
    int          cmax_v [2] = '{255, 3};
    logic [15:0] rst_v  [2] = '{16'hB, 16'h3};
    int          m_n    [2];
    logic [15:0] m_bits [2];
    logic [15:0] m_pat  [2];
    int          m_cnt  [2];
    logic        m_det  [2];

    task automatic model_step(input int i);
        logic [15:0] mask;
        logic        hit;
        mask = 16'((32'd1 << len_v[i]) - 1);
        if (reset) begin
            m_pat[i] = rst_v[i]; m_n[i] = 0; m_bits[i] = '0; m_cnt[i] = 0; m_det[i] = 1'b0;
            return;
        end
        hit = 1'b0;
        if (d_load[i]) begin
            m_pat[i] = d_pin[i] & mask;
            m_n[i]   = 0;
        end else if (d_valid[i]) begin
            m_bits[i] = {m_bits[i][14:0], d_bit[i]};
            m_n[i]    = m_n[i] + 1;
            hit = (m_n[i] >= len_v[i]) && ((m_bits[i] & mask) == m_pat[i]);
            if (hit && !d_ov[i]) m_n[i] = 0;
            if (hit && m_cnt[i] < cmax_v[i]) m_cnt[i] = m_cnt[i] + 1;
        end
        m_det[i] = hit;
        if (d_clr[i]) m_cnt[i] = 0;
    endtask

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
        model_step(0);
        model_step(1);
        check("det0", 32'(if0.detector_out), 32'(m_det[0]));
        check("cnt0", 32'(if0.match_count),  32'(m_cnt[0]));
        check("pat0", 32'(if0.pattern_q),    32'(m_pat[0]));
        check("det1", 32'(if1.detector_out), 32'(m_det[1]));
        check("cnt1", 32'(if1.match_count),  32'(m_cnt[1]));
        check("pat1", 32'(if1.pattern_q),    32'(m_pat[1]));
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            d_valid[i] = 1'b0; d_bit[i] = 1'b0; d_load[i] = 1'b0;
            d_pin[i] = '0; d_clr[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // send n bits of seq (MSB first) to instance i, with gap idle cycles after each bit
    task automatic send_bits(input int i, input logic [15:0] seq, input int n, input int gap);
        for (int k = n - 1; k >= 0; k--) begin
            d_valid[i] = 1'b1;
            d_bit[i]   = seq[k];
            tick();
            d_valid[i] = 1'b0;
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        d_ov[0] = 1'b1; d_ov[1] = 1'b1;
        idle_all();
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_bits[i] = '0; m_pat[i] = rst_v[i]; m_cnt[i] = 0; m_det[i] = 1'b0;
        end
        do_reset();
        check("rst_pat0", 32'(if0.pattern_q), 32'h0000000B);
        check("rst_cnt0", 32'(if0.match_count), 32'h0);
        check("rst_det0", 32'(if0.detector_out), 32'h0);

        // overlapping: 1011011 -> two matches
        d_ov[0] = 1'b1;
        send_bits(0, 16'b1011011, 7, 0);
        tick();
        check("ovl_cnt", 32'(if0.match_count), 32'd2);

        // non-overlapping: same stream -> one match
        do_reset();
        d_ov[0] = 1'b0;
        send_bits(0, 16'b1011011, 7, 0);
        tick();
        check("novl_cnt", 32'(if0.match_count), 32'd1);

        // valid gaps of 3 cycles between bits
        do_reset();
        d_ov[0] = 1'b1;
        send_bits(0, 16'b1011, 4, 3);
        check("gap_cnt", 32'(if0.match_count), 32'd1);

        // pattern reload; the bit presented with the load is discarded
        d_load[0] = 1'b1; d_pin[0] = 16'b0110; d_valid[0] = 1'b1; d_bit[0] = 1'b1;
        tick();
        d_load[0] = 1'b0; d_valid[0] = 1'b0;
        check("load_pat", 32'(if0.pattern_q), 32'b0110);
        send_bits(0, 16'b0110, 4, 0);
        check("load_hit", 32'(if0.detector_out), 32'd1);
        check("load_cnt", 32'(if0.match_count), 32'd2);
        send_bits(0, 16'b1011, 4, 0);
        check("load_miss", 32'(if0.match_count), 32'd2);

        // saturation on the 2-bit counter, then clear coincident with a hit
        do_reset();
        d_ov[1] = 1'b1;
        send_bits(1, 16'b111111, 6, 0);
        check("sat_cnt", 32'(if1.match_count), 32'd3);
        d_clr[1] = 1'b1;
        send_bits(1, 16'b1, 1, 0);
        d_clr[1] = 1'b0;
        check("clr_cnt", 32'(if1.match_count), 32'd0);
        check("clr_det", 32'(if1.detector_out), 32'd1);

        // reset mid-stream discards the partial match
        do_reset();
        d_ov[0] = 1'b1;
        send_bits(0, 16'b101, 3, 0);
        do_reset();
        check("mid_pat", 32'(if0.pattern_q), 32'h0000000B);
        send_bits(0, 16'b1, 1, 0);
        check("mid_nodet", 32'(if0.detector_out), 32'd0);
        send_bits(0, 16'b1011, 4, 0);
        check("mid_det", 32'(if0.detector_out), 32'd1);

        // random traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                d_valid[i] = ($urandom_range(0, 3) != 0);
                d_bit[i]   = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 19) == 0) d_ov[i] = ~d_ov[i];
                d_load[i]  = ($urandom_range(0, 39) == 0);
                d_pin[i]   = 16'($urandom());
                d_clr[i]   = ($urandom_range(0, 49) == 0);
            end
            tick();
        end
        reset = 1'b0;
        idle_all();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
